result_text_streamer: RTL

RESULT_TEXT_STREAMER -- requirements
Module: result_text_streamer

---
 rtl/result_text_streamer_pkg.sv | 16 +
 rtl/result_text_streamer_bcd_dabble_seq.sv | 50 +++++
 rtl/result_text_streamer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/result_text_streamer_pkg.sv
// Shared FSM state encoding and ASCII codes for the result text streamer.
package result_text_streamer_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CONVERT,
      EMIT_SIGN,
      EMIT_DIG,
      EMIT_END
   } state_t;

   localparam logic [7:0] ASCII_ZERO  = 8'h30;
   localparam logic [7:0] ASCII_MINUS = 8'h2D;
   localparam logic [7:0] ASCII_CR    = 8'h0D;

endpackage

// File: rtl/result_text_streamer_bcd_dabble_seq.sv
// Sequential binary-to-BCD converter: shift-add-3, one input bit per clock.
module bcd_dabble_seq
   import result_text_streamer_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic [WIDTH-1:0]      bin,
   output logic                  done,
   output logic [DIGITS*4-1:0]   bcd
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   logic [WIDTH-1:0]    bin_q;
   logic [DIGITS*4-1:0] bcd_q;
   logic [DIGITS*4-1:0] bcd_adj;
   logic [CNT_W-1:0]    cnt_q;

   always_comb begin
      bcd_adj = bcd_q;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5)
            bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
   end

   // bin_q is the magnitude register; it empties into the BCD field as it shifts
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bin_q <= '0;
         bcd_q <= '0;
         cnt_q <= '0;
      end else if (load) begin
         bin_q <= bin;
         bcd_q <= '0;
         cnt_q <= CNT_W'(WIDTH);
      end else if (cnt_q != '0) begin
         {bcd_q, bin_q} <= {bcd_adj[DIGITS*4-2:0], bin_q, 1'b0};
         cnt_q          <= cnt_q - 1'b1;
      end
   end

   assign done = (cnt_q == '0);
   assign bcd  = bcd_q;

endmodule

// File: rtl/result_text_streamer.sv
// Streams a binary result as decimal ASCII text, sharing the output with a keyboard.
module result_text_streamer
   import result_text_streamer_pkg::*;
#(
   parameter int         WIDTH     = 16,
   parameter int         DIGITS    = 5,
   parameter int         SIGNED_EN = 0,
   parameter int         END_EN    = 1,
   parameter logic [7:0] END_CHAR  = ASCII_CR
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             res_valid,
   input  logic [WIDTH-1:0] res_data,
   output logic             res_ready,
   input  logic             key_valid,
   input  logic [7:0]       key_ascii,
   output logic             key_ready,
   output logic             out_valid,
   output logic [7:0]       out_ascii,
   input  logic             out_ready,
   output logic             busy
);

   localparam int CW         = WIDTH + SIGNED_EN;
   localparam int PW         = $clog2(DIGITS);
   // Digit count of 2**WIDTH-1; the default 16-bit/5-digit pairing sits exactly on it
   localparam int MIN_DIGITS = (WIDTH * 30103) / 100000 + 1;

   if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
      $error("result_text_streamer: WIDTH must be 2..32");
   end
   if (DIGITS < MIN_DIGITS) begin : g_bad_digits
      $error("result_text_streamer: DIGITS too small for WIDTH");
   end

   state_t              state_q, state_d;
   logic [7:0]          char_q, char_d;
   logic [PW-1:0]       ptr_q, ptr_d, msd;
   logic                neg_q, load, done;
   logic [CW-1:0]       mag;
   logic [DIGITS*4-1:0] bcd;

   function automatic logic [7:0] digit_char(input logic [PW-1:0] idx);
      return ASCII_ZERO + {4'h0, bcd[4*idx +: 4]};
   endfunction

   always_comb begin
      mag = CW'(res_data);
      if (SIGNED_EN != 0 && res_data[WIDTH-1])
         mag = CW'(-{res_data[WIDTH-1], res_data});
   end

   bcd_dabble_seq #(
      .WIDTH  (CW),
      .DIGITS (DIGITS)
   ) u_dabble (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load),
      .bin   (mag),
      .done  (done),
      .bcd   (bcd)
   );

   always_comb begin
      msd = '0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (bcd[4*i +: 4] != 4'd0)
            msd = PW'(i);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         char_q  <= '0;
         ptr_q   <= '0;
         neg_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         char_q  <= char_d;
         ptr_q   <= ptr_d;
         if (load)
            neg_q <= (SIGNED_EN != 0) && res_data[WIDTH-1];
      end
   end

   // The next character is computed on each handshake and registered with the state
   always_comb begin
      state_d   = state_q;
      char_d    = char_q;
      ptr_d     = ptr_q;
      load      = 1'b0;
      res_ready = 1'b0;
      key_ready = 1'b0;
      out_valid = 1'b0;
      out_ascii = char_q;
      busy      = 1'b1;
      unique case (state_q)
         IDLE: begin
            busy      = 1'b0;
            res_ready = 1'b1;
            out_ascii = rst_n ? key_ascii : char_q;
            if (res_valid) begin
               load    = 1'b1;
               state_d = CONVERT;
            end else begin
               out_valid = key_valid & rst_n;
               key_ready = out_ready & rst_n;
            end
         end
         CONVERT: begin
            if (done) begin
               ptr_d = msd;
               if (neg_q) begin
                  state_d = EMIT_SIGN;
                  char_d  = ASCII_MINUS;
               end else begin
                  state_d = EMIT_DIG;
                  char_d  = digit_char(msd);
               end
            end
         end
         EMIT_SIGN: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = EMIT_DIG;
               char_d  = digit_char(ptr_q);
            end
         end
         EMIT_DIG: begin
            out_valid = 1'b1;
            if (out_ready) begin
               if (ptr_q == '0) begin
                  if (END_EN != 0) begin
                     state_d = EMIT_END;
                     char_d  = END_CHAR;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  ptr_d  = ptr_q - 1'b1;
                  char_d = digit_char(ptr_q - 1'b1);
               end
            end
         end
         EMIT_END: begin
            out_valid = 1'b1;
            if (out_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule
